// File: rtl/mem_request_master_pkg.sv
// Shared definitions for the memory_unit request master: memory_unit func codes,
// core op codes, FSM states and the op/phase -> func mapping.
package mem_request_master_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;

  localparam logic [1:0] FUNC_GET_FREE     = 2'd0;
  localparam logic [1:0] FUNC_GET_CONTENTS = 2'd1;
  localparam logic [1:0] FUNC_SET_CONTENTS = 2'd2;

  // A CONS always allocates exactly one cell before writing it.
  localparam int CONS_COUNT = 1;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ALLOC = 2'b10,
    OP_CONS  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [1:0] op_func(input op_e op, input logic phase);
    case (op)
      OP_READ:  op_func = FUNC_GET_CONTENTS;
      OP_WRITE: op_func = FUNC_SET_CONTENTS;
      OP_ALLOC: op_func = FUNC_GET_FREE;
      OP_CONS:  op_func = phase ? FUNC_SET_CONTENTS : FUNC_GET_FREE;
      default:  op_func = FUNC_GET_CONTENTS;
    endcase
  endfunction

endpackage

// File: rtl/mem_request_master_timer.sv
// Per-transaction watchdog: clearable, enabled while a memory op is outstanding,
// saturates at TIMEOUT and flags done there.
module mem_req_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_request_master.sv
// Initiator for the memory_unit func/execute/is_ready interface: turns core
// READ/WRITE/ALLOC/CONS requests into memory transactions with a watchdog.
module mem_request_master
  import mem_request_master_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        mem_func,
  output logic              mem_execute,
  output logic [ADDR_W-1:0] mem_address1,
  output logic [ADDR_W-1:0] mem_address2,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_is_ready,
  input  logic [DATA_W-1:0] mem_read_data1,
  input  logic [DATA_W-1:0] mem_read_data2,
  input  logic [ADDR_W-1:0] mem_free_addr
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              phase_q, phase_d;
  logic              wait2_q, wait2_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              err_q, err_d;
  logic              timer_clear, timer_en, timer_done;

  mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .done   (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_READ;
      phase_q  <= 1'b0;
      wait2_q  <= 1'b0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      data_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      raddr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      phase_q  <= phase_d;
      wait2_q  <= wait2_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      data_q   <= data_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      raddr_q  <= raddr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    phase_d     = phase_q;
    wait2_d     = wait2_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    data_d      = data_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    raddr_d     = raddr_q;
    err_d       = err_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (req_valid) begin
          op_d     = op_e'(req_op);
          addr1_d  = req_addr1;
          addr2_d  = req_addr2;
          data_d   = req_data;
          phase_d  = 1'b0;
          rdata1_d = '0;
          rdata2_d = '0;
          raddr_d  = '0;
          err_d    = 1'b0;
          state_d  = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        timer_en = 1'b1;
        wait2_d  = 1'b0;
        if (timer_done) begin
          rdata1_d = '0;
          rdata2_d = '0;
          raddr_d  = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else if (mem_is_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        timer_en = 1'b1;
        wait2_d  = 1'b1;
        // First WAIT cycle still shows the pre-execute ready, so it is ignored.
        if (timer_done) begin
          rdata1_d = '0;
          rdata2_d = '0;
          raddr_d  = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else if (wait2_q && mem_is_ready) begin
          case (op_q)
            OP_READ: begin
              rdata1_d = mem_read_data1;
              rdata2_d = mem_read_data2;
              state_d  = ST_RESP;
            end
            OP_WRITE: state_d = ST_RESP;
            OP_ALLOC: begin
              raddr_d = mem_free_addr;
              state_d = ST_RESP;
            end
            OP_CONS: begin
              if (!phase_q) begin
                raddr_d     = mem_free_addr;
                phase_d     = 1'b1;
                timer_clear = 1'b1;
                state_d     = ST_ISSUE;
              end else begin
                state_d = ST_RESP;
              end
            end
            default: state_d = ST_RESP;
          endcase
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == ST_IDLE) && !rst;
    busy           = (state_q != ST_IDLE);
    rsp_valid      = (state_q == ST_RESP);
    rsp_data1      = rdata1_q;
    rsp_data2      = rdata2_q;
    rsp_addr       = raddr_q;
    rsp_err        = err_q;
    mem_execute    = (state_q == ST_ISSUE) && mem_is_ready && !timer_done;
    mem_func       = 2'd0;
    mem_address1   = '0;
    mem_address2   = '0;
    mem_write_data = '0;
    // CONS phase 1 writes the cell that phase 0 just allocated.
    if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
      mem_func       = op_func(op_q, phase_q);
      mem_address1   = ((op_q == OP_CONS) && phase_q) ? raddr_q : addr1_q;
      mem_address2   = addr2_q;
      mem_write_data = ((op_q == OP_CONS) && !phase_q) ? DATA_W'(CONS_COUNT) : data_q;
    end else begin
      mem_func       = 2'd0;
      mem_address1   = '0;
      mem_address2   = '0;
      mem_write_data = '0;
    end
  end

endmodule

// File: tb/tb_mem_request_master.sv
// Bench for mem_request_master: a memory_unit stand-in with fixed service times,
// a transaction-level reference model and a per-cycle compare process.
module tb_mem_request_master;
  import mem_request_master_pkg::*;

  localparam int AW         = MEM_ADDR_W;
  localparam int DW         = MEM_DATA_W;
  localparam int TO         = 8;
  localparam int S_RD       = 3;
  localparam int S_WR       = 3;
  localparam int S_FREE     = 2;
  localparam int FREE_LIMIT = 8;
  localparam int DEPTH      = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr1 = '0;
  logic [AW-1:0] req_addr2 = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err, busy;
  logic [1:0]    mem_func;
  logic          mem_execute;
  logic [AW-1:0] mem_address1, mem_address2;
  logic [DW-1:0] mem_write_data;
  logic          mem_is_ready;
  logic [DW-1:0] mem_read_data1, mem_read_data2;
  logic [AW-1:0] mem_free_addr;

  always #5 clk = ~clk;

  mem_request_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_addr(rsp_addr),
    .rsp_err(rsp_err), .busy(busy),
    .mem_func(mem_func), .mem_execute(mem_execute),
    .mem_address1(mem_address1), .mem_address2(mem_address2),
    .mem_write_data(mem_write_data), .mem_is_ready(mem_is_ready),
    .mem_read_data1(mem_read_data1), .mem_read_data2(mem_read_data2),
    .mem_free_addr(mem_free_addr)
  );

  // memory_unit stand-in; an allocation past FREE_LIMIT hangs it forever.
  logic [DW-1:0] ram [DEPTH];
  int            mem_cnt;
  logic          mem_hung;
  int            free_ptr;
  logic          mem_rst = 1'b1;
  logic [DW-1:0] rd1, rd2;
  logic [AW-1:0] faddr;

  assign mem_is_ready   = (mem_cnt == 0) && !mem_hung;
  assign mem_read_data1 = rd1;
  assign mem_read_data2 = rd2;
  assign mem_free_addr  = faddr;

  always @(posedge clk or posedge mem_rst) begin
    if (mem_rst) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(32'h100 + i);
      ram[3]   <= 16'h0011;
      ram[4]   <= 16'h0022;
      mem_cnt  <= 0;
      mem_hung <= 1'b0;
      free_ptr <= 1;
      rd1      <= '0;
      rd2      <= '0;
      faddr    <= '0;
    end else if (mem_execute) begin
      case (mem_func)
        FUNC_GET_CONTENTS: begin
          rd1     <= ram[mem_address1];
          rd2     <= ram[mem_address2];
          mem_cnt <= S_RD;
        end
        FUNC_SET_CONTENTS: begin
          ram[mem_address1] <= mem_write_data;
          mem_cnt           <= S_WR;
        end
        FUNC_GET_FREE: begin
          if (free_ptr + int'(mem_write_data) > FREE_LIMIT) begin
            mem_hung <= 1'b1;
          end else begin
            faddr    <= AW'(free_ptr);
            free_ptr <= free_ptr + int'(mem_write_data);
            mem_cnt  <= S_FREE;
          end
        end
        default: mem_cnt <= S_RD;
      endcase
    end else if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  // Reference model state and the expectation for the transaction in flight.
  logic [DW-1:0] ref_ram [DEPTH];
  int            ref_free;
  logic [DW-1:0] e_d1, e_d2;
  logic [AW-1:0] e_addr;
  logic          e_err;
  int            e_lat, e_exec;
  logic [1:0]    e_func;
  bit            l_chk;
  logic [DW-1:0] l_d1, l_d2;
  logic [AW-1:0] l_addr;
  logic          l_err;
  int            l_lat;

  int   cyc = 0;
  int   acc_cyc = 0;
  int   exec_n = 0;
  int   exec_snap = 0;
  int   txn = 0;
  bit   pending = 1'b0;
  logic [1:0] last_func = 2'd0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_ram[i] = DW'(32'h100 + i);
    ref_ram[3] = 16'h0011;
    ref_ram[4] = 16'h0022;
    ref_free   = 1;
  endtask

  // Latency of one memory op = issue cycle + ignored WAIT cycle + service time.
  task automatic model(input logic [1:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [DW-1:0] d);
    e_d1 = '0; e_d2 = '0; e_addr = '0; e_err = 1'b0; e_exec = 1;
    case (op)
      2'b00: begin
        e_d1 = ref_ram[a1]; e_d2 = ref_ram[a2];
        e_lat = 2 + S_RD; e_func = FUNC_GET_CONTENTS;
      end
      2'b01: begin
        ref_ram[a1] = d;
        e_lat = 2 + S_WR; e_func = FUNC_SET_CONTENTS;
      end
      2'b10: begin
        e_func = FUNC_GET_FREE;
        if (ref_free + int'(d) > FREE_LIMIT) begin
          e_err = 1'b1; e_lat = TO + 1;
        end else begin
          e_addr = AW'(ref_free); ref_free += int'(d); e_lat = 2 + S_FREE;
        end
      end
      default: begin
        e_addr = AW'(ref_free); ref_ram[ref_free] = d; ref_free += 1;
        e_lat = (2 + S_FREE) + (2 + S_WR); e_exec = 2; e_func = FUNC_SET_CONTENTS;
      end
    endcase
  endtask

  task automatic lit(input bit en, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                     input logic [AW-1:0] a, input logic err, input int lat);
    l_chk = en; l_d1 = d1; l_d2 = d2; l_addr = a; l_err = err; l_lat = lat;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [DW-1:0] d, input int hold, input bit abort);
    int n;
    model(op, a1, a2, d);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr1 = a1; req_addr2 = a2; req_data = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    acc_cyc = cyc; exec_snap = exec_n; txn++; pending = 1'b1;
    #1 req_valid = 1'b0; req_op = 2'b00; req_addr1 = '0; req_addr2 = '0; req_data = '0;
    if (abort) begin
      n = 0;
      while ((exec_n - exec_snap) < 2 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 pending = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      n = 0;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      if (hold > 0) begin
        req_valid = 1'b1; req_op = 2'b01; req_addr1 = 8'hEE; req_data = 16'hDEAD;
        repeat (hold) @(negedge clk);
        req_valid = 1'b0; req_op = 2'b00; req_addr1 = '0; req_data = '0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0; pending = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: samples DUT outputs on every falling edge.
  initial begin
    int el;
    int seen_txn;
    seen_txn = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_execute) begin
        exec_n++;
        last_func = mem_func;
      end
      if (rst) begin
        chk("reset_ctrl", {req_ready, rsp_valid, busy, mem_execute, rsp_err}, 128'd0);
        chk("reset_mem_bus", {mem_func, mem_address1, mem_address2, mem_write_data}, 128'd0);
        chk("reset_rsp_bus", {rsp_data1, rsp_data2, rsp_addr}, 128'd0);
      end else if (!pending) begin
        chk("idle_ctrl", {req_ready, busy, rsp_valid, mem_execute}, 128'b1000);
      end else begin
        el = cyc - acc_cyc - 1;
        if (rsp_valid && txn != seen_txn) begin
          seen_txn = txn;
          chk("exec_count", 128'(exec_n - exec_snap), 128'(e_exec));
          chk("exec_func", last_func, e_func);
          if (l_chk && l_lat >= 0) chk("lit_latency", 128'(el), 128'(l_lat));
        end
        chk("rsp_valid_timing", rsp_valid, el >= e_lat);
        if (rsp_valid) begin
          chk("rsp_fields", {rsp_data1, rsp_data2, rsp_addr, rsp_err}, {e_d1, e_d2, e_addr, e_err});
          chk("resp_hold_ctrl", {req_ready, busy, mem_execute}, 128'b010);
          if (l_chk) chk("lit_fields", {rsp_data1, rsp_data2, rsp_addr, rsp_err},
                         {l_d1, l_d2, l_addr, l_err});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ref_reset();
    lit(1'b0, '0, '0, '0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mem_rst = 1'b0;

    lit(1'b1, 16'h0011, 16'h0022, 8'h00, 1'b0, 5);
    do_req(2'b00, 8'd3, 8'd4, 16'h0000, 0, 1'b0);
    lit(1'b1, 16'h0000, 16'h0000, 8'h00, 1'b0, 5);
    do_req(2'b01, 8'd5, 8'd0, 16'h00AB, 0, 1'b0);
    lit(1'b1, 16'h00AB, 16'h0106, 8'h00, 1'b0, 5);
    do_req(2'b00, 8'd5, 8'd6, 16'h0000, 10, 1'b0);
    lit(1'b1, 16'h0000, 16'h0000, 8'h01, 1'b0, 4);
    do_req(2'b10, 8'd0, 8'd0, 16'd2, 0, 1'b0);
    lit(1'b1, 16'h0000, 16'h0000, 8'h03, 1'b0, -1);
    do_req(2'b11, 8'd0, 8'd0, 16'h0007, 0, 1'b0);
    lit(1'b1, 16'h0007, 16'h00AB, 8'h00, 1'b0, 5);
    do_req(2'b00, 8'd3, 8'd5, 16'h0000, 0, 1'b0);

    lit(1'b0, '0, '0, '0, 1'b0, -1);
    do_req(2'b01, 8'h20, 8'h00, 16'h1234, 0, 1'b0);
    do_req(2'b00, 8'h20, 8'h21, 16'h0000, 2, 1'b0);

    // Reset lands in CONS phase-1 WAIT; the memory still completes its write.
    do_req(2'b11, 8'd0, 8'd0, 16'h0055, 0, 1'b1);
    repeat (6) @(negedge clk);
    lit(1'b1, 16'h0055, 16'h0007, 8'h00, 1'b0, 5);
    do_req(2'b00, 8'd4, 8'd3, 16'h0000, 0, 1'b0);

    lit(1'b1, 16'h0000, 16'h0000, 8'h00, 1'b1, 9);
    do_req(2'b10, 8'd0, 8'd0, 16'd10, 3, 1'b0);

    @(negedge clk); mem_rst = 1'b1;
    @(negedge clk); mem_rst = 1'b0;
    ref_reset();
    lit(1'b1, 16'h0011, 16'h0022, 8'h00, 1'b0, 5);
    do_req(2'b00, 8'd3, 8'd4, 16'h0000, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
